// File: rtl/secuenciador_lecturas_mem_pkg.sv
// Shared types for the memory read sequencer.
// Holds the FSM state encoding and a clog2 helper for counter widths.
package secuenciador_lecturas_mem_pkg;

  typedef enum logic [2:0] {
    REPOSO  = 3'd0,
    CARGA   = 3'd1,
    LECTURA = 3'd2,
    DRENAJE = 3'd3,
    FIN     = 3'd4
  } estado_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/FlipFlopD_Habilitado.sv
// Enabled D register with synchronous active-high reset.
// Ports: clk, reset, habilitado (load enable), d -> q.
module FlipFlopD_Habilitado #(
  parameter int ANCHO = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             habilitado,
  input  logic [ANCHO-1:0] d,
  output logic [ANCHO-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else if (habilitado) q <= d;
  end

endmodule

// File: rtl/secuenciador_lecturas_mem_contador.sv
// contador_pendientes: up/down count of reads accepted but not returned.
// Ports: clk, reset, incrementar, decrementar -> lleno (at MAXIMO), vacio.
module contador_pendientes
  import secuenciador_lecturas_mem_pkg::*;
#(
  parameter int MAXIMO = 4,
  parameter int W      = clog2(MAXIMO + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic incrementar,
  input  logic decrementar,
  output logic lleno,
  output logic vacio
);

  logic [W-1:0] cuenta_q;

  assign lleno = (cuenta_q == W'(MAXIMO));
  assign vacio = (cuenta_q == '0);

  // Accept and return in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      cuenta_q <= '0;
    end else if (incrementar && !decrementar && !lleno) begin
      cuenta_q <= cuenta_q + 1'b1;
    end else if (decrementar && !incrementar && !vacio) begin
      cuenta_q <= cuenta_q - 1'b1;
    end
  end

endmodule

// File: rtl/secuenciador_lecturas_mem.sv
// Read sequencer: issues word reads from memory and fills line buffers
// round-robin. Ports: start/config in, memory read port (mem_*), line
// buffer write port (buffer_*), ocupado/terminado status.
// Optional SECUENCIADOR_ABORTO_EN adds input abortar (early stop).
module secuenciador_lecturas_mem
  import secuenciador_lecturas_mem_pkg::*;
#(
  parameter int BITS_BUS_DATOS_INSTR = 21,
  parameter int BITS_BUFFERS_IMAGEN  = 3,
  parameter int BITS_DATOS_MEM       = 32,
  parameter int PALABRAS_POR_BUFFER  = 128,
  parameter int MAX_PENDIENTES       = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            inicio,
`ifdef SECUENCIADOR_ABORTO_EN
  input  logic                            abortar,
`endif
  input  logic [BITS_BUS_DATOS_INSTR-1:0] direccion_mem_inicio_imagen,
  input  logic [BITS_BUS_DATOS_INSTR-1:0] cantidad_lecturas_mem,
  input  logic [BITS_BUFFERS_IMAGEN-1:0]  cantidad_buffers_internos,
  output logic [BITS_BUS_DATOS_INSTR-1:0] mem_direccion,
  output logic                            mem_lectura,
  input  logic                            mem_espera,
  input  logic                            mem_dato_valido,
  input  logic [BITS_DATOS_MEM-1:0]       mem_dato,
  input  logic                            buffer_listo,
  output logic                            buffer_escritura,
  output logic [BITS_DATOS_MEM-1:0]       buffer_dato,
  output logic [BITS_BUFFERS_IMAGEN-1:0]  buffer_indice,
  output logic                            ocupado,
  output logic                            terminado
);

  localparam int BD = BITS_BUS_DATOS_INSTR;
  localparam int BB = BITS_BUFFERS_IMAGEN;
  localparam int AP0 = clog2(PALABRAS_POR_BUFFER);
  localparam int AP = (AP0 < 1) ? 1 : AP0;

  estado_t estado_q;
  logic [BD-1:0] cfg_dir, cfg_cant, enviados_q;
  logic [BB-1:0] cfg_buf, ultimo_buf, indice_q;
  logic [AP-1:0] palabra_q;
  logic [BITS_DATOS_MEM-1:0] dato_q;
  logic escritura_q, retenido_q;
  logic en_carga, acepta, ultimo, recibe;
  logic lleno, vacio, parar, corta;

  assign en_carga = (estado_q == CARGA);

  FlipFlopD_Habilitado #(.ANCHO(BD)) u_cfg_dir (
    .clk(clk), .reset(reset), .habilitado(en_carga),
    .d(direccion_mem_inicio_imagen), .q(cfg_dir)
  );

  FlipFlopD_Habilitado #(.ANCHO(BD)) u_cfg_cant (
    .clk(clk), .reset(reset), .habilitado(en_carga),
    .d(cantidad_lecturas_mem), .q(cfg_cant)
  );

  FlipFlopD_Habilitado #(.ANCHO(BB)) u_cfg_buf (
    .clk(clk), .reset(reset), .habilitado(en_carga),
    .d(cantidad_buffers_internos), .q(cfg_buf)
  );

  contador_pendientes #(.MAXIMO(MAX_PENDIENTES)) u_pend (
    .clk(clk), .reset(reset),
    .incrementar(acepta), .decrementar(recibe),
    .lleno(lleno), .vacio(vacio)
  );

  // A count of zero buffers behaves as a single buffer.
  assign ultimo_buf = (cfg_buf == '0) ? '0 : cfg_buf - 1'b1;

  // retenido_q keeps a stalled request up regardless of buffer_listo.
  assign mem_lectura = (estado_q == LECTURA) &&
    (retenido_q || (!lleno && buffer_listo && !parar));
  assign mem_direccion = cfg_dir + enviados_q;
  assign acepta = mem_lectura && !mem_espera;
  assign ultimo = acepta && (enviados_q == cfg_cant - 1'b1);
  assign recibe = mem_dato_valido && (estado_q != REPOSO);

`ifdef SECUENCIADOR_ABORTO_EN
  logic aborto_q;
  assign parar = aborto_q;
  // A stalled request must still complete before draining.
  assign corta = (abortar || aborto_q) &&
    !(mem_lectura && mem_espera);
`else
  assign parar = 1'b0;
  assign corta = 1'b0;
`endif

  assign buffer_escritura = escritura_q;
  assign buffer_dato      = dato_q;
  assign buffer_indice    = indice_q;
  assign ocupado          = (estado_q != REPOSO);
  assign terminado        = (estado_q == FIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q    <= REPOSO;
      enviados_q  <= '0;
      retenido_q  <= 1'b0;
      escritura_q <= 1'b0;
      dato_q      <= '0;
      indice_q    <= '0;
      palabra_q   <= '0;
`ifdef SECUENCIADOR_ABORTO_EN
      aborto_q    <= 1'b0;
`endif
    end else begin
      retenido_q  <= mem_lectura && mem_espera;
      escritura_q <= recibe;
      if (recibe) dato_q <= mem_dato;

      if (en_carga) begin
        palabra_q <= '0;
        indice_q  <= '0;
      end else if (escritura_q) begin
        if (palabra_q == AP'(PALABRAS_POR_BUFFER - 1)) begin
          palabra_q <= '0;
          indice_q  <= (indice_q == ultimo_buf) ?
                       '0 : indice_q + 1'b1;
        end else begin
          palabra_q <= palabra_q + 1'b1;
        end
      end

      case (estado_q)
        REPOSO: begin
          if (inicio) estado_q <= CARGA;
        end
        CARGA: begin
          enviados_q <= '0;
`ifdef SECUENCIADOR_ABORTO_EN
          aborto_q   <= 1'b0;
`endif
          estado_q <= (cantidad_lecturas_mem == '0) ?
                      FIN : LECTURA;
        end
        LECTURA: begin
          if (acepta) enviados_q <= enviados_q + 1'b1;
`ifdef SECUENCIADOR_ABORTO_EN
          if (abortar) aborto_q <= 1'b1;
`endif
          if (ultimo || corta) estado_q <= DRENAJE;
        end
        DRENAJE: begin
          if (vacio) estado_q <= FIN;
        end
        FIN: begin
          estado_q <= REPOSO;
        end
        default: estado_q <= REPOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_lecturas_mem.sv
// Bench for secuenciador_lecturas_mem: memory model with fixed latency,
// scoreboard of expected buffer writes, one task per scenario.
module tb_secuenciador_lecturas_mem;

  localparam int MAXP = 4;
  localparam int PPB  = 4;

  logic clk = 0;
  logic reset = 1;
  logic inicio = 0;
`ifdef SECUENCIADOR_ABORTO_EN
  logic abortar = 0;
`endif
  logic [20:0] dir_ini = '0;
  logic [20:0] cant = '0;
  logic [2:0]  nbuf = '0;
  logic [20:0] mem_direccion;
  logic        mem_lectura;
  logic        mem_espera = 0;
  logic        mem_dato_valido = 0;
  logic [31:0] mem_dato = '0;
  logic        buffer_listo = 1;
  logic        buffer_escritura;
  logic [31:0] buffer_dato;
  logic [2:0]  buffer_indice;
  logic        ocupado;
  logic        terminado;

  secuenciador_lecturas_mem #(
    .PALABRAS_POR_BUFFER(PPB),
    .MAX_PENDIENTES(MAXP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .inicio(inicio),
`ifdef SECUENCIADOR_ABORTO_EN
    .abortar(abortar),
`endif
    .direccion_mem_inicio_imagen(dir_ini),
    .cantidad_lecturas_mem(cant),
    .cantidad_buffers_internos(nbuf),
    .mem_direccion(mem_direccion),
    .mem_lectura(mem_lectura),
    .mem_espera(mem_espera),
    .mem_dato_valido(mem_dato_valido),
    .mem_dato(mem_dato),
    .buffer_listo(buffer_listo),
    .buffer_escritura(buffer_escritura),
    .buffer_dato(buffer_dato),
    .buffer_indice(buffer_indice),
    .ocupado(ocupado),
    .terminado(terminado)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [20:0] a;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] sb[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 1;
  int n_acc = 0;
  int n_wr = 0;
  int n_term = 0;
  int n_held = 0;
  int outst = 0;
  int wr_last_cyc = 0;
  int term_cyc = 0;
  int stall_idx = -1;
  int stall_left = 0;
  int exp_nb = 1;
  logic [20:0] exp_base = '0;
  logic [20:0] held_addr = '1;
  bit prev_stall = 0;
  bit discard = 0;

  function automatic logic [31:0] dato_de(input logic [20:0] a);
    return {a, 11'h3C5};
  endfunction

  // Memory model: returns in order, lat cycles after accept.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      mem_dato_valido = 1;
      mem_dato = dato_de(mq[0].a);
      void'(mq.pop_front());
    end else begin
      mem_dato_valido = 0;
      mem_dato = '0;
    end
    #1;
    if (stall_left > 0 && mem_lectura && n_acc == stall_idx) begin
      mem_espera = 1;
      stall_left--;
    end else begin
      mem_espera = 0;
    end
  end

  // Monitor and scoreboard.
  always @(negedge clk) begin
    mreq_t r;
    int ei;
    total++;
    if (mem_lectura && !prev_stall && (outst >= MAXP || !buffer_listo)) begin
      bad++;
      $display("FAIL req_gate: mem_lectura=1 outst=%0d listo=%0b",
               outst, buffer_listo);
    end
    if (mem_lectura && mem_direccion == held_addr) n_held++;
    if (mem_lectura && !mem_espera) begin
      total++;
      if (mem_direccion !== exp_base + 21'(n_acc)) begin
        bad++;
        $display("FAIL addr: got %h want %h",
                 mem_direccion, exp_base + 21'(n_acc));
      end
      r.due = cyc + lat;
      r.a = mem_direccion;
      mq.push_back(r);
      sb.push_back(dato_de(mem_direccion));
      n_acc++;
      outst++;
    end
    if (mem_dato_valido) outst--;
    total++;
    if (outst > MAXP) begin
      bad++;
      $display("FAIL outstanding: got %0d max %0d", outst, MAXP);
    end
    if (buffer_escritura) begin
      total++;
      if (discard) begin
        bad++;
        $display("FAIL late_write: got write %h want none", buffer_dato);
      end else if (sb.size() == 0) begin
        bad++;
        $display("FAIL extra_write: got %h want none", buffer_dato);
      end else begin
        ei = (n_wr / PPB) % exp_nb;
        if (buffer_dato !== sb[0] || buffer_indice !== 3'(ei)) begin
          bad++;
          $display("FAIL write: got %h idx %0d want %h idx %0d",
                   buffer_dato, buffer_indice, sb[0], ei);
        end
        void'(sb.pop_front());
      end
      n_wr++;
      wr_last_cyc = cyc;
    end
    if (terminado) begin
      n_term++;
      term_cyc = cyc;
    end
    prev_stall = mem_lectura && mem_espera;
  end

  task automatic ciclos(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic arrancar(input logic [20:0] b, input logic [20:0] c,
                          input logic [2:0] nb);
    dir_ini = b;
    cant = c;
    nbuf = nb;
    exp_base = b;
    exp_nb = (nb == 0) ? 1 : int'(nb);
    n_acc = 0;
    n_wr = 0;
    n_term = 0;
    n_held = 0;
    inicio = 1;
    ciclos(1);
    inicio = 0;
  endtask

  task automatic esperar_fin(input int limite, output bit ok);
    ok = 0;
    for (int i = 0; i < limite; i++) begin
      if (n_term > 0) begin
        ok = 1;
        break;
      end
      ciclos(1);
    end
  endtask

  task automatic fin_normal(input string nom, input int c, input int limite);
    bit ok;
    esperar_fin(limite, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_timeout: got no terminado want one", nom);
    end
    ciclos(3);
    total++;
    if (n_acc !== c) begin
      bad++;
      $display("FAIL %s_reads: got %0d want %0d", nom, n_acc, c);
    end
    total++;
    if (n_wr !== c) begin
      bad++;
      $display("FAIL %s_writes: got %0d want %0d", nom, n_wr, c);
    end
    total++;
    if (n_term !== 1) begin
      bad++;
      $display("FAIL %s_term: got %0d want 1", nom, n_term);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_left: got %0d want 0", nom, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1;
    ciclos(2);
    total++;
    if ({mem_lectura, ocupado, terminado, buffer_escritura,
         mem_direccion, buffer_indice, buffer_dato} !== '0) begin
      bad++;
      $display("FAIL reset_outs: got nonzero want 0 (lect=%b ocu=%b dir=%h)",
               mem_lectura, ocupado, mem_direccion);
    end
    reset = 0;
    ciclos(1);
  endtask

  task automatic test_basico();
    lat = 1;
    arrancar(21'h100, 21'd5, 3'd2);
    ciclos(2);
    inicio = 1;
    ciclos(1);
    inicio = 0;
    fin_normal("basic", 5, 100);
    total++;
    if (term_cyc !== wr_last_cyc + 1) begin
      bad++;
      $display("FAIL basic_term_time: got %0d want %0d",
               term_cyc, wr_last_cyc + 1);
    end
  endtask

  task automatic test_cero();
    bit [1:0] esp [3];
    esp[0] = 2'b10;
    esp[1] = 2'b11;
    esp[2] = 2'b00;
    arrancar(21'h50, 21'd0, 3'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({ocupado, terminado} !== esp[i] || mem_lectura !== 1'b0) begin
        bad++;
        $display("FAIL zero_c%0d: got ocu=%b term=%b lect=%b want %b",
                 i, ocupado, terminado, mem_lectura, esp[i]);
      end
    end
    ciclos(2);
  endtask

  task automatic test_espera();
    lat = 1;
    held_addr = 21'h201;
    stall_idx = 1;
    stall_left = 3;
    arrancar(21'h200, 21'd4, 3'd1);
    fin_normal("stall", 4, 100);
    total++;
    if (n_held !== 4) begin
      bad++;
      $display("FAIL stall_hold: got %0d cycles want 4", n_held);
    end
    stall_idx = -1;
    held_addr = '1;
  endtask

  task automatic test_latencia();
    lat = 10;
    arrancar(21'h300, 21'd12, 3'd1);
    ciclos(15);
    buffer_listo = 0;
    ciclos(4);
    buffer_listo = 1;
    fin_normal("latency", 12, 400);
  endtask

  task automatic test_indice();
    lat = 2;
    arrancar(21'h40, 21'd14, 3'd3);
    fin_normal("index", 14, 200);
    lat = 1;
    arrancar(21'h80, 21'd6, 3'd0);
    fin_normal("index0", 6, 100);
  endtask

  task automatic test_reset_medio();
    bit hit;
    lat = 10;
    arrancar(21'h500, 21'd20, 3'd2);
    hit = 0;
    for (int i = 0; i < 50; i++) begin
      if (outst == 3) begin
        hit = 1;
        break;
      end
      ciclos(1);
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL midreset_wait: got outst=%0d want 3", outst);
    end
    buffer_listo = 0;
    reset = 1;
    ciclos(1);
    total++;
    if ({mem_lectura, ocupado, terminado, buffer_escritura,
         mem_direccion, buffer_indice} !== '0) begin
      bad++;
      $display("FAIL midreset_outs: got lect=%b ocu=%b dir=%h want 0",
               mem_lectura, ocupado, mem_direccion);
    end
    discard = 1;
    sb.delete();
    reset = 0;
    buffer_listo = 1;
    ciclos(20);
    total++;
    if (mq.size() != 0 || outst != 0) begin
      bad++;
      $display("FAIL midreset_drain: got q=%0d outst=%0d want 0",
               mq.size(), outst);
    end
    total++;
    if (n_term !== 0) begin
      bad++;
      $display("FAIL midreset_term: got %0d want 0", n_term);
    end
    discard = 0;
  endtask

`ifdef SECUENCIADOR_ABORTO_EN
  task automatic test_aborto();
    bit ok;
    lat = 4;
    arrancar(21'h600, 21'd30, 3'd2);
    for (int i = 0; i < 100; i++) begin
      if (n_acc >= 6) break;
      ciclos(1);
    end
    abortar = 1;
    ciclos(1);
    abortar = 0;
    esperar_fin(200, ok);
    ciclos(3);
    total++;
    if (!ok || n_term !== 1) begin
      bad++;
      $display("FAIL abort_term: got %0d want 1", n_term);
    end
    total++;
    if (n_acc >= 30 || n_acc < 6) begin
      bad++;
      $display("FAIL abort_reads: got %0d want 6..29", n_acc);
    end
    total++;
    if (n_wr !== n_acc || sb.size() != 0) begin
      bad++;
      $display("FAIL abort_writes: got %0d want %0d", n_wr, n_acc);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basico();
    test_cero();
    test_espera();
    test_latencia();
    test_indice();
    test_reset_medio();
`ifdef SECUENCIADOR_ABORTO_EN
    test_aborto();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
